// File: rtl/rf_pkg.sv
// Register-file geometry and the writeback request record used by the write arbiter.
`ifndef DEFINITIONS_SV
`define DEFINITIONS_SV
`define WORD_SIZE 32
`endif

package rf_pkg;
  localparam int WORD_SIZE         = `WORD_SIZE;
  localparam int REG_FILE_SIZE     = 32;
  localparam int REG_FILE_ADDR_LEN = 5;

  typedef struct packed {
    logic [REG_FILE_ADDR_LEN-1:0] dest;
    logic [WORD_SIZE-1:0]         data;
  } wb_req_t;

  // A one-requester arbiter still needs a 1-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/definitions.sv
// Project-wide datapath width shared by the writeback path and the register file.
`ifndef DEFINITIONS_SV
`define DEFINITIONS_SV
`define WORD_SIZE 32
`endif

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first valid request at or after the pointer wins.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N = 3,
  localparam int PW = ptr_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_next_ptr,
  output logic          o_valid
);

  int w_dist;
  int w_best;

  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise paths with no winner infer latches.
    o_grant    = '0;
    o_next_ptr = i_ptr;
    o_valid    = 1'b0;
    w_dist     = 0;
    w_best     = 0;
    // Smallest rotational distance from the pointer is the highest priority.
    for (int i = 0; i < N; i++) begin
      w_dist = (i + N - int'(i_ptr)) % N;
      if (i_req[i] && (!o_valid || w_dist < w_best)) begin
        w_best     = w_dist;
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_next_ptr = PW'((i + 1) % N);
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin sharing of the register-file write port plus a per-register pending
// scoreboard that lets decode stall on writes still in flight.
module rf_write_arbiter
  import rf_pkg::wb_req_t, rf_pkg::WORD_SIZE, rf_pkg::ptr_width;
#(
  parameter int NUM_REQ           = 3,
  parameter int REG_FILE_SIZE     = rf_pkg::REG_FILE_SIZE,
  parameter int REG_FILE_ADDR_LEN = rf_pkg::REG_FILE_ADDR_LEN
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*REG_FILE_ADDR_LEN-1:0] req_dest,
  input  logic [NUM_REQ*WORD_SIZE-1:0]       req_data,
  input  logic                               issue_valid,
  input  logic [REG_FILE_ADDR_LEN-1:0]       issue_dest,
  output logic                               issue_ready,
  input  logic [REG_FILE_ADDR_LEN-1:0]       src1,
  input  logic [REG_FILE_ADDR_LEN-1:0]       src2,
  output logic                               busy1,
  output logic                               busy2,
  output logic                               rf_write_en,
  output logic [REG_FILE_ADDR_LEN-1:0]       rf_dest,
  output logic [WORD_SIZE-1:0]               rf_write_val
);

  localparam int PW = ptr_width(NUM_REQ);

  logic [PW-1:0]            r_ptr;
  logic                     r_wen;
  wb_req_t                  r_wb;
  logic [REG_FILE_SIZE-1:0] r_pending;

  logic [PW-1:0]            w_next_ptr;
  logic [NUM_REQ-1:0]       w_grant;
  logic                     w_xfer;
  logic                     w_write;
  logic                     w_issue_ok;
  wb_req_t                  w_win;
  logic [REG_FILE_SIZE-1:0] w_pending_next;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .i_req      (req_valid),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_next_ptr (w_next_ptr),
    .o_valid    (w_xfer)
  );

  assign req_ready = w_grant;

  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_win.dest = req_dest[i*REG_FILE_ADDR_LEN +: REG_FILE_ADDR_LEN];
        w_win.data = req_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // Writes to r0 consume the grant but never reach the register file.
  assign w_write = w_xfer && (w_win.dest != '0);

  assign w_issue_ok  = (issue_dest == '0) || !r_pending[issue_dest];
  assign issue_ready = w_issue_ok;
  assign busy1       = (src1 != '0) && r_pending[src1];
  assign busy2       = (src2 != '0) && r_pending[src2];

  // Set after clear: an issue to a non-pending register being written must stay pending.
  always_comb begin
    w_pending_next = r_pending;
    if (r_wen) w_pending_next[r_wb.dest] = 1'b0;
    if (issue_valid && w_issue_ok && (issue_dest != '0)) w_pending_next[issue_dest] = 1'b1;
  end

  // NOTE: the scoreboard is a flop vector rather than a RAM, so it can and must be cleared by reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      r_ptr     <= '0;
      r_wen     <= 1'b0;
      r_wb      <= '0;
      r_pending <= '0;
    end else begin
      r_wen     <= w_write;
      r_pending <= w_pending_next;
      if (w_write) r_wb  <= w_win;
      if (w_xfer)  r_ptr <= w_next_ptr;
    end
  end

  assign rf_write_en  = r_wen;
  assign rf_dest      = r_wb.dest;
  assign rf_write_val = r_wb.data;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and randomized bench for rf_write_arbiter against a cycle-level behavioural model.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int N  = 3;
  localparam int AW = REG_FILE_ADDR_LEN;
  localparam int W  = WORD_SIZE;
  localparam int RS = REG_FILE_SIZE;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_dest;
  logic [N*W-1:0]  req_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_dest;
  logic            issue_ready;
  logic [AW-1:0]   src1, src2;
  logic            busy1, busy2;
  logic            rf_write_en;
  logic [AW-1:0]   rf_dest;
  logic [W-1:0]    rf_write_val;

  logic [AW-1:0]   tdest [N];
  logic [W-1:0]    tdata [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_dest = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_dest[i*AW +: AW] = tdest[i];
      req_data[i*W +: W]   = tdata[i];
    end
  end

  rf_write_arbiter #(
    .NUM_REQ(N), .REG_FILE_SIZE(RS), .REG_FILE_ADDR_LEN(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_data(req_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
    .src1(src1), .src2(src2), .busy1(busy1), .busy2(busy2),
    .rf_write_en(rf_write_en), .rf_dest(rf_dest), .rf_write_val(rf_write_val)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: pointer as an integer, pending as a bit per register,
  // and the single write expected on the port during the next cycle.
  int            m_ptr;
  logic [RS-1:0] m_pending;
  logic          m_wen;
  logic [AW-1:0] m_dest;
  logic [W-1:0]  m_val;
  bit            m_live = 1'b0;

  initial begin
    int            win;
    int            c;
    logic [N-1:0]  v;
    logic [N*AW-1:0] td;
    logic [N*W-1:0]  tv;
    logic [N-1:0]  exp_ready;
    logic          exp_ir, exp_b1, exp_b2;
    logic [AW-1:0] wdest;
    logic [W-1:0]  wval;
    forever begin
      @(negedge clk);
      win = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        v = req_valid >> c;
        if (win < 0 && v[0]) win = c;
      end
      exp_ready = (win >= 0) ? (N'(1) << win) : '0;
      wdest = '0;
      wval  = '0;
      if (win >= 0) begin
        td    = req_dest >> (win * AW);
        tv    = req_data >> (win * W);
        wdest = td[AW-1:0];
        wval  = tv[W-1:0];
      end
      exp_ir = (issue_dest == 0) || !m_pending[issue_dest];
      exp_b1 = (src1 != 0) && m_pending[src1];
      exp_b2 = (src2 != 0) && m_pending[src2];

      if (m_live) begin
        check("m_req_ready",   req_ready,   exp_ready);
        check("m_issue_ready", issue_ready, exp_ir);
        check("m_busy1",       busy1,       exp_b1);
        check("m_busy2",       busy2,       exp_b2);
        check("m_write_en",    rf_write_en, m_wen);
        check("m_dest",        rf_dest,     m_dest);
        check("m_write_val",   rf_write_val, m_val);
      end

      if (rst) begin
        m_ptr     = 0;
        m_pending = '0;
        m_wen     = 1'b0;
        m_dest    = '0;
        m_val     = '0;
        m_live    = 1'b1;
      end else begin
        if (m_wen) m_pending[m_dest] = 1'b0;
        if (issue_valid && exp_ir && issue_dest != 0) m_pending[issue_dest] = 1'b1;
        m_wen = 1'b0;
        if (win >= 0) begin
          m_ptr = (win + 1) % N;
          if (wdest != 0) begin
            m_wen  = 1'b1;
            m_dest = wdest;
            m_val  = wval;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_abc();
    tdest[0] = 5'd1;  tdest[1] = 5'd2;  tdest[2] = 5'd3;
    tdata[0] = 32'hA; tdata[1] = 32'hB; tdata[2] = 32'hC;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; issue_valid = 1'b0; issue_dest = '0; src1 = '0; src2 = '0;
    for (int i = 0; i < N; i++) begin tdest[i] = '0; tdata[i] = '0; end
    step(); step();
    rst = 1'b0;

    // Idle after reset.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_write_en", rf_write_en, 1'b0);
      check("idle_busy1", busy1, 1'b0);
      check("idle_busy2", busy2, 1'b0);
      check("idle_issue_ready", issue_ready, 1'b1);
      check("idle_req_ready", req_ready, 3'b000);
      step();
    end

    // All requesters held valid: grants rotate 0,1,2 with writes one cycle behind.
    set_abc();
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_grant", req_ready, 3'b001 << (k % 3));
      if (k > 0) begin
        check("rr_write_en", rf_write_en, 1'b1);
        check("rr_dest", rf_dest, 64'((k - 1) % 3 + 1));
        check("rr_val", rf_write_val, 64'(32'hA + (k - 1) % 3));
      end
      step();
    end
    req_valid = '0;
    @(negedge clk);
    check("rr_last_dest", rf_dest, 5'd3);
    check("rr_last_val", rf_write_val, 32'hC);
    step();

    // Scoreboard round trip on r7.
    issue_valid = 1'b1; issue_dest = 5'd7; src1 = 5'd7;
    @(negedge clk);
    check("r7_issue_ready", issue_ready, 1'b1);
    check("r7_busy_before", busy1, 1'b0);
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    check("r7_busy_set", busy1, 1'b1);
    step();
    req_valid = 3'b010; tdest[1] = 5'd7; tdata[1] = 32'h55;
    @(negedge clk);
    check("r7_grant", req_ready, 3'b010);
    check("r7_busy_hs", busy1, 1'b1);
    step();
    req_valid = '0; issue_valid = 1'b1; issue_dest = 5'd7;
    @(negedge clk);
    check("r7_write_en", rf_write_en, 1'b1);
    check("r7_dest", rf_dest, 5'd7);
    check("r7_val", rf_write_val, 32'h55);
    check("r7_busy_wen", busy1, 1'b1);
    check("r7_issue_stall", issue_ready, 1'b0);
    step();
    @(negedge clk);
    check("r7_wen_drop", rf_write_en, 1'b0);
    check("r7_busy_clear", busy1, 1'b0);
    check("r7_issue_accept", issue_ready, 1'b1);
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    check("r7_busy_again", busy1, 1'b1);
    step();

    // Write to r0 consumes the grant without a register-file write.
    req_valid = 3'b001; tdest[0] = 5'd0; tdata[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    check("r0_grant", req_ready, 3'b001);
    step();
    req_valid = '0;
    @(negedge clk);
    check("r0_no_write", rf_write_en, 1'b0);
    check("r0_dest_hold", rf_dest, 5'd7);
    check("r0_val_hold", rf_write_val, 32'h55);
    step();
    set_abc();
    req_valid = 3'b111;
    @(negedge clk);
    check("r0_ptr_advanced", req_ready, 3'b010);
    step();
    req_valid = '0;
    @(negedge clk);
    check("r0_next_dest", rf_dest, 5'd2);
    check("r0_next_val", rf_write_val, 32'hB);
    step();

    // Issue to r0 is always accepted and never marks r0 busy.
    issue_valid = 1'b1; issue_dest = 5'd0; src1 = 5'd0;
    @(negedge clk);
    check("i0_issue_ready", issue_ready, 1'b1);
    check("i0_busy", busy1, 1'b0);
    step();
    issue_valid = 1'b0;
    @(negedge clk);
    check("i0_busy_after", busy1, 1'b0);
    step();

    // Reset while r4/r5 are pending and a handshake is in progress.
    issue_valid = 1'b1; issue_dest = 5'd4;
    @(negedge clk);
    check("rs_issue4", issue_ready, 1'b1);
    step();
    issue_dest = 5'd5; src1 = 5'd4; src2 = 5'd5;
    @(negedge clk);
    check("rs_busy4", busy1, 1'b1);
    check("rs_issue5", issue_ready, 1'b1);
    step();
    req_valid = 3'b001; tdest[0] = 5'd4; tdata[0] = 32'h44;
    issue_dest = 5'd9; rst = 1'b1;
    @(negedge clk);
    check("rs_busy4_pre", busy1, 1'b1);
    check("rs_busy5_pre", busy2, 1'b1);
    check("rs_grant_pre", req_ready, 3'b001);
    step();
    rst = 1'b0; req_valid = '0; issue_valid = 1'b0;
    @(negedge clk);
    check("rs_write_en", rf_write_en, 1'b0);
    check("rs_dest", rf_dest, 5'd0);
    check("rs_val", rf_write_val, 32'h0);
    check("rs_busy4", busy1, 1'b0);
    check("rs_busy5", busy2, 1'b0);
    step();
    req_valid = 3'b111; src1 = 5'd9; src2 = 5'd7;
    @(negedge clk);
    check("rs_ptr_zero", req_ready, 3'b001);
    check("rs_busy9", busy1, 1'b0);
    check("rs_busy7", busy2, 1'b0);
    step();

    // Randomized traffic; small register range keeps scoreboard collisions frequent.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst         = ($urandom_range(0, 199) == 0);
      req_valid   = N'($urandom);
      for (int i = 0; i < N; i++) begin
        tdest[i] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 8));
        tdata[i] = W'($urandom);
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_dest  = AW'($urandom_range(0, 8));
      src1        = AW'($urandom_range(0, 8));
      src2        = AW'($urandom_range(0, 8));
      step();
    end

    rst = 1'b0; req_valid = '0; issue_valid = 1'b0;
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port among `NUM_REQ` writeback sources (ALU, load unit, multiply/divide) using round-robin arbitration, and registers the winning write toward the register file. Maintains a per-register pending scoreboard, set when a long-latency instruction issues and cleared when its write lands, so decode can stall on RAW hazards. Sits between the writeback sources and the register file write port (`write_en`/`dest`/`write_val`).

## Interface
- `NUM_REQ`, 3, number of writeback requesters (2..8)
- `REG_FILE_SIZE`, 32, number of architectural registers
- `REG_FILE_ADDR_LEN`, 5, register address width
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  requester i has a write pending
- `req_ready`  out  NUM_REQ  requester i granted this cycle (one-hot or zero)
- `req_dest`  in  NUM_REQ*REG_FILE_ADDR_LEN  flattened dest addresses, slice i = requester i
- `req_data`  in  NUM_REQ*`WORD_SIZE`  flattened write data, slice i = requester i
- `issue_valid`  in  1  instruction with long-latency result wants to issue
- `issue_dest`  in  REG_FILE_ADDR_LEN  its destination register
- `issue_ready`  out  1  issue accepted this cycle
- `src1`, `src2`  in  REG_FILE_ADDR_LEN each  decode read addresses
- `busy1`, `busy2`  out  1 each  source register has a write in flight
- `rf_write_en`  out  1  to register file `write_en`
- `rf_dest`  out  REG_FILE_ADDR_LEN  to register file `dest`
- `rf_write_val`  out  `WORD_SIZE`  to register file `write_val`

## Operation
- Arbitration: round-robin over `req_valid`, search starting at pointer `rr_ptr`; winner i gets `req_ready[i]=1` combinationally; transfer = `req_valid[i] && req_ready[i]`.
- After a transfer from i, `rr_ptr <= (i+1) mod NUM_REQ`; no transfer leaves `rr_ptr` unchanged.
- At most one transfer per cycle; `req_ready` never asserted for a non-valid requester.
- Transfer with dest 0: accepted (consumes grant, advances pointer), but `rf_write_en` stays 0 that next cycle; scoreboard untouched.
- Transfer with dest≠0: next cycle `rf_write_en=1`, `rf_dest`/`rf_write_val` = transferred values; otherwise `rf_write_en=0`, dest/val hold last values.
- Scoreboard `pending[REG_FILE_SIZE]`: `issue_ready = (issue_dest==0) || !pending[issue_dest]` (registered state only); on accepted issue with dest≠0, set `pending[issue_dest]`.
- Clear `pending[rf_dest]` at the edge ending a cycle with `rf_write_en=1` (same edge the register file captures data).
- Writes to non-pending registers are legal; no scoreboard effect.
- `busy1 = (src1!=0) && pending[src1]`, likewise `busy2`; combinational from state.
- `pending[0]` is never set.

## Timing
- Reset: `req_ready`=0 while inputs idle, `rf_write_en`=0, `rf_dest`=0, `rf_write_val`=0, `rr_ptr`=0, all `pending`=0, `busy1`/`busy2`=0, `issue_ready`=1.
- Reset mid-operation: in-flight registered write discarded (`rf_write_en`=0 next cycle), all pending cleared; `rst` overrides same-cycle transfers and issues.
- Latency: request handshake to `rf_write_en` = 1 cycle; `rf_write_en` to `busy` deassert = 1 cycle, after which the register file holds the value.
- An issue to a register whose write is in its `rf_write_en` cycle stalls (`issue_ready=0`) and is accepted the following cycle.
- Throughput: one write per cycle sustained; starvation-free: any held request granted within `NUM_REQ` cycles.

## Structure
- `WORD_SIZE` comes from `definitions.sv`; add package `rf_pkg` holding `REG_FILE_SIZE`, `REG_FILE_ADDR_LEN` defaults and a `wb_req_t` struct (dest, data).
- Sub-module `rr_arbiter` (parameter `N`): request vector + pointer in, one-hot grant and updated pointer out, purely combinational; pointer register lives in `rf_write_arbiter`.

## Test plan
- Reset, then all idle -> `rf_write_en`=0, `busy1`=`busy2`=0, `issue_ready`=1 for 5 cycles.
- All 3 requesters valid continuously (dests 1,2,3, data 0xA,0xB,0xC) -> grants 0,1,2,0,... one per cycle; `rf_write_en` pattern dest 1,2,3 with matching data 1 cycle later.
- Issue dest 7; `src1`=7 -> `busy1`=1; requester 1 writes r7=0x55 -> `rf_write_en` next cycle, `busy1`=0 the cycle after; second issue to r7 stalled during `rf_write_en` cycle, accepted next.
- Requester 0 writes dest 0 with data 0xFFFF_FFFF -> `req_ready[0]`=1, `rf_write_en` stays 0, `rr_ptr` advances to 1.
- Issue dest 0 -> `issue_ready`=1, `busy1` with `src1`=0 stays 0.
- Issue r4, r5 pending, handshake in flight, assert `rst` one cycle -> `rf_write_en`=0 next cycle, `busy` for r4/r5 =0, `rr_ptr`=0.
